// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction prefetch unit.
//   fetch_state_t  - run/idle/debug control states
//   IF_*_OFS       - bit offsets inside an in-flight tracker entry
//                    {addr, is_dbg, valid}, addr starting at IF_ADDR_OFS
//   clog2()        - pointer width helper for the FIFO
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DBG  = 2'd2
  } fetch_state_t;

  localparam int IF_VALID_OFS = 0;
  localparam int IF_DBG_OFS   = 1;
  localparam int IF_ADDR_OFS  = 2;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO holding {instruction, pc} pairs.
// Ports:
//   clk, rst_n          - clock, synchronous active-low clear
//   flush               - synchronous clear (push/pop ignored that cycle)
//   push, push_data     - write request and data (dropped when full, unless popping)
//   pop                 - read request (ignored when empty)
//   head                - combinational head entry
//   count, full, empty  - occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int PTR_W = clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  // Qualify requests; a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    do_pop  = pop & (cnt != '0) & ~flush;
    do_push = push & ((cnt != CNT_W'(DEPTH)) | do_pop) & ~flush;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage write; contents need no clear since the head is qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_prefetch.sv
// fetch_prefetch: sequential instruction prefetcher between program ROM and decode.
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   rom_ren/rom_raddr (out, reg)    - ROM read strobe/address
//   rom_rdata                       - ROM data, valid ROM_LAT cycles after rom_ren
//   dbg_en                          - debug mode: halts fetch, pc <= 0, flush
//   dbg_rom_ren/dbg_rom_raddr       - debug ROM read (priority over fetch)
//   dbg_rom_rdata/dbg_rom_rvalid    - registered debug read return (one-cycle pulse)
//   dbg_inst_en/dbg_inst            - inject an instruction (pc 0) into the FIFO
//   timer_state                     - run enable
//   pc_wen/pc_wdata                 - redirect (ignored in debug)
//   inst_valid/inst_ready/inst/inst_pc - decoder valid/ready interface (FIFO head)
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 8,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              rom_ren,
  output logic [ADDR_W-1:0] rom_raddr,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic              dbg_en,
  input  logic              dbg_rom_ren,
  input  logic [ADDR_W-1:0] dbg_rom_raddr,
  output logic [DATA_W-1:0] dbg_rom_rdata,
  output logic              dbg_rom_rvalid,
  input  logic              dbg_inst_en,
  input  logic [DATA_W-1:0] dbg_inst,
  input  logic              timer_state,
  input  logic              pc_wen,
  input  logic [ADDR_W-1:0] pc_wdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CNT_W  = clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W  = ADDR_W + IF_ADDR_OFS;
  localparam int PUSH_W = DATA_W + ADDR_W;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              rom_is_dbg;              // tag of the read currently on rom_ren
  logic              rom_ren_nxt;
  logic              rom_is_dbg_nxt;
  logic [ADDR_W-1:0] rom_raddr_nxt;
  logic [ENT_W-1:0]  pipe     [ROM_LAT];      // pipe[ROM_LAT-1] lines up with rom_rdata
  logic [ENT_W-1:0]  pipe_nxt [ROM_LAT];
  logic [ENT_W-1:0]  exit_entry;
  logic              dbg_entry;
  logic              redirect;
  logic              fetch_ret;
  logic              dbg_ret;
  logic              issue;
  logic [7:0]        inflight;
  logic              fifo_flush;
  logic              fifo_push;
  logic [PUSH_W-1:0] fifo_push_data;
  logic              fifo_pop;
  logic [PUSH_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // Per-cycle events: flushes, returns leaving the tracker, and fetch credit.
  always_comb begin
    dbg_entry  = dbg_en & (state != ST_DBG);
    redirect   = pc_wen & ~dbg_en & (state != ST_DBG);
    exit_entry = pipe[ROM_LAT-1];
    // A fetch return in a flush cycle belongs to the old stream and is dropped.
    fetch_ret  = exit_entry[IF_VALID_OFS] & ~exit_entry[IF_DBG_OFS] & ~redirect & ~dbg_entry;
    dbg_ret    = exit_entry[IF_VALID_OFS] & exit_entry[IF_DBG_OFS] & ~dbg_entry;
    inflight   = 8'(rom_ren & ~rom_is_dbg);
    for (int i = 0; i < ROM_LAT; i++) begin
      inflight = inflight + 8'(pipe[i][IF_VALID_OFS] & ~pipe[i][IF_DBG_OFS]);
    end
    // Reserving FIFO space at issue time means a fetch return never meets a full FIFO.
    issue = (state == ST_RUN) & ~dbg_en & ~redirect & ~dbg_rom_ren &
            ((8'(fifo_count) + inflight) < 8'(FIFO_DEPTH));
  end

  // Next ROM request, pc and tracker contents.
  always_comb begin
    rom_ren_nxt    = dbg_rom_ren | issue;
    rom_is_dbg_nxt = dbg_rom_ren;
    rom_raddr_nxt  = rom_raddr;
    if (dbg_rom_ren) begin
      rom_raddr_nxt = dbg_rom_raddr;
    end else if (issue) begin
      rom_raddr_nxt = pc;
    end else begin
      rom_raddr_nxt = rom_raddr;
    end

    pc_nxt = pc;
    if (dbg_entry) begin
      pc_nxt = '0;
    end else if (redirect) begin
      pc_nxt = pc_wdata;
    end else if (issue) begin
      pc_nxt = pc + ADDR_W'(1);
    end else begin
      pc_nxt = pc;
    end

    // Redirect kills fetch entries only; debug entry kills everything in flight.
    pipe_nxt[0]                        = '0;
    pipe_nxt[0][IF_VALID_OFS]          = rom_ren & ~dbg_entry & (rom_is_dbg | ~redirect);
    pipe_nxt[0][IF_DBG_OFS]            = rom_is_dbg;
    pipe_nxt[0][IF_ADDR_OFS +: ADDR_W] = rom_raddr;
    for (int i = 1; i < ROM_LAT; i++) begin
      pipe_nxt[i]               = pipe[i-1];
      pipe_nxt[i][IF_VALID_OFS] = pipe[i-1][IF_VALID_OFS] & ~dbg_entry &
                                  (pipe[i-1][IF_DBG_OFS] | ~redirect);
    end
  end

  // FIFO write source selection and decoder side.
  always_comb begin
    fifo_flush = redirect | dbg_entry;
    fifo_pop   = inst_valid & inst_ready;
    if (fetch_ret) begin
      fifo_push      = 1'b1;
      fifo_push_data = {rom_rdata, exit_entry[IF_ADDR_OFS +: ADDR_W]};
    end else if (dbg_inst_en & ~fifo_full) begin
      fifo_push      = 1'b1;
      fifo_push_data = {dbg_inst, {ADDR_W{1'b0}}};
    end else begin
      fifo_push      = 1'b0;
      fifo_push_data = '0;
    end
    inst_valid = ~fifo_empty;
    if (inst_valid) begin
      inst    = fifo_head[ADDR_W +: DATA_W];
      inst_pc = fifo_head[ADDR_W-1:0];
    end else begin
      inst    = '0;
      inst_pc = '0;
    end
  end

  // Control state transitions, debug first.
  always_comb begin
    state_nxt = state;
    if (dbg_en) begin
      state_nxt = ST_DBG;
    end else begin
      case (state)
        ST_DBG:  state_nxt = ST_IDLE;
        ST_IDLE: state_nxt = timer_state ? ST_RUN : ST_IDLE;
        ST_RUN:  state_nxt = timer_state ? ST_RUN : ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, pc, ROM request, tracker and debug return registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      pc             <= '0;
      rom_ren        <= 1'b0;
      rom_is_dbg     <= 1'b0;
      rom_raddr      <= '0;
      dbg_rom_rvalid <= 1'b0;
      dbg_rom_rdata  <= '0;
      for (int i = 0; i < ROM_LAT; i++) pipe[i] <= '0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      rom_ren        <= rom_ren_nxt;
      rom_is_dbg     <= rom_is_dbg_nxt;
      rom_raddr      <= rom_raddr_nxt;
      dbg_rom_rvalid <= dbg_ret;
      if (dbg_ret) dbg_rom_rdata <= rom_rdata;
      for (int i = 0; i < ROM_LAT; i++) pipe[i] <= pipe_nxt[i];
    end
  end

  fetch_fifo #(
    .WIDTH (PUSH_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed scenarios plus randomized traffic for fetch_prefetch.
// The reference is a stream model: the next instruction the decoder accepts must be
// the one at the expected pc (restarted on redirect), and the number of fetches issued
// but not yet consumed may never exceed the FIFO depth.
module tb_fetch_prefetch;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 8;
  localparam int ROM_LAT    = 3;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rom_ren;
  logic [ADDR_W-1:0] rom_raddr;
  logic [DATA_W-1:0] rom_rdata;
  logic              dbg_en;
  logic              dbg_rom_ren;
  logic [ADDR_W-1:0] dbg_rom_raddr;
  logic [DATA_W-1:0] dbg_rom_rdata;
  logic              dbg_rom_rvalid;
  logic              dbg_inst_en;
  logic [DATA_W-1:0] dbg_inst;
  logic              timer_state;
  logic              pc_wen;
  logic [ADDR_W-1:0] pc_wdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;

  always #5 clk = ~clk;

  fetch_prefetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rom_ren(rom_ren), .rom_raddr(rom_raddr),
    .rom_rdata(rom_rdata), .dbg_en(dbg_en), .dbg_rom_ren(dbg_rom_ren),
    .dbg_rom_raddr(dbg_rom_raddr), .dbg_rom_rdata(dbg_rom_rdata),
    .dbg_rom_rvalid(dbg_rom_rvalid), .dbg_inst_en(dbg_inst_en), .dbg_inst(dbg_inst),
    .timer_state(timer_state), .pc_wen(pc_wen), .pc_wdata(pc_wdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rom_f(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16];
  endfunction

  // next-cycle input values
  logic              nx_rst_n = 1'b0, nx_timer = 1'b0, nx_ready = 1'b0;
  logic              nx_dbg_en = 1'b0, nx_dbg_rd = 1'b0, nx_inj = 1'b0, nx_pc_wen = 1'b0;
  logic [ADDR_W-1:0] nx_dbg_addr = '0, nx_pc_wdata = '0;
  logic [DATA_W-1:0] nx_dbg_inst = '0;

  // ROM model history and stream model state
  logic              hist_v [ROM_LAT+1];
  logic [ADDR_W-1:0] hist_a [ROM_LAT+1];
  logic              chk_stream = 1'b0;
  logic [ADDR_W-1:0] exp_pc = '0;
  int                outstanding = 0;
  int                pops = 0;

  // One clock: at the falling edge, feed the ROM, apply inputs, update the model.
  task automatic cycle();
    @(negedge clk);
    for (int i = ROM_LAT; i > 0; i--) begin
      hist_v[i] = hist_v[i-1];
      hist_a[i] = hist_a[i-1];
    end
    hist_v[0] = rom_ren;
    hist_a[0] = rom_raddr;
    rom_rdata = hist_v[ROM_LAT] ? rom_f(hist_a[ROM_LAT]) : DATA_W'($urandom);
    if (chk_stream && rom_ren) begin
      outstanding++;
      check_val("credit", 32'(outstanding <= FIFO_DEPTH), 32'd1);
    end
    rst_n = nx_rst_n; timer_state = nx_timer; inst_ready = nx_ready;
    dbg_en = nx_dbg_en; dbg_rom_ren = nx_dbg_rd; dbg_rom_raddr = nx_dbg_addr;
    dbg_inst_en = nx_inj; dbg_inst = nx_dbg_inst; pc_wen = nx_pc_wen; pc_wdata = nx_pc_wdata;
    if (chk_stream && inst_valid && inst_ready) begin
      check_val("inst_pc", 32'(inst_pc), 32'(exp_pc));
      check_val("inst", 32'(inst), 32'(rom_f(exp_pc)));
      exp_pc = exp_pc + 24'd1;
      outstanding--;
      pops++;
    end
    if (chk_stream && pc_wen && !dbg_en) begin
      exp_pc      = pc_wdata;
      outstanding = 0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ren_cnt;
    int p0;
    for (int i = 0; i <= ROM_LAT; i++) begin
      hist_v[i] = 1'b0;
      hist_a[i] = '0;
    end
    rom_rdata = '0;

    // reset state
    repeat (3) cycle();
    check_val("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_val("rst_rom_ren", 32'(rom_ren), 32'd0);
    check_val("rst_rom_raddr", 32'(rom_raddr), 32'd0);
    check_val("rst_inst", 32'(inst), 32'd0);
    check_val("rst_inst_pc", 32'(inst_pc), 32'd0);
    check_val("rst_dbg_rvalid", 32'(dbg_rom_rvalid), 32'd0);
    check_val("rst_dbg_rdata", 32'(dbg_rom_rdata), 32'd0);

    // start-up: first instruction at pc 0 after 1 + ROM_LAT + 1 cycles in ST_RUN
    nx_rst_n = 1'b1; nx_timer = 1'b1; nx_ready = 1'b1;
    chk_stream = 1'b1; exp_pc = '0; outstanding = 0;
    cycle();
    k = 0;
    do begin cycle(); k++; end while (!inst_valid && k < 20);
    check_val("start_latency", 32'(k), 32'(ROM_LAT + 3));
    check_val("start_pc", 32'(inst_pc), 32'd0);
    repeat (10) cycle();

    // decoder stall: credit saturates at FIFO_DEPTH, fetch stops, then drains in order
    nx_ready = 1'b0;
    repeat (12) cycle();
    ren_cnt = 0;
    repeat (8) begin cycle(); ren_cnt += 32'(rom_ren); end
    check_val("stall_no_ren", 32'(ren_cnt), 32'd0);
    check_val("stall_outstanding", 32'(outstanding), 32'(FIFO_DEPTH));
    check_val("stall_valid", 32'(inst_valid), 32'd1);
    p0 = pops;
    nx_ready = 1'b1;
    repeat (12) cycle();
    check_val("drain_progress", 32'(pops - p0 >= FIFO_DEPTH), 32'd1);

    // redirect while reads are in flight
    k = 0;
    while (!rom_ren && k < 10) begin cycle(); k++; end
    check_val("redir_inflight", 32'(rom_ren), 32'd1);
    nx_pc_wen = 1'b1; nx_pc_wdata = 24'h000100;
    cycle();
    nx_pc_wen = 1'b0;
    k = 0;
    do begin cycle(); k++; end while (!inst_valid && k < 20);
    check_val("redir_latency", 32'(k), 32'(ROM_LAT + 3));
    check_val("redir_pc", 32'(inst_pc), 32'h000100);
    repeat (8) cycle();

    // pc wrap
    nx_pc_wen = 1'b1; nx_pc_wdata = 24'hFFFFFE;
    cycle();
    nx_pc_wen = 1'b0;
    repeat (20) cycle();
    check_val("wrap_reached", 32'(exp_pc < 24'h000100), 32'd1);

    // debug: flush, ROM peek, injection
    nx_dbg_en = 1'b1; nx_ready = 1'b0; chk_stream = 1'b0;
    cycle();
    repeat (ROM_LAT + 4) cycle();
    check_val("dbg_fifo_empty", 32'(inst_valid), 32'd0);
    check_val("dbg_no_fetch", 32'(rom_ren), 32'd0);
    nx_dbg_rd = 1'b1; nx_dbg_addr = 24'h000010;
    cycle();
    nx_dbg_rd = 1'b0;
    k = 0;
    do begin
      cycle(); k++;
      if (k == 1) begin
        check_val("dbg_rom_ren", 32'(rom_ren), 32'd1);
        check_val("dbg_rom_raddr", 32'(rom_raddr), 32'h000010);
      end
    end while (!dbg_rom_rvalid && k < 20);
    check_val("dbg_rd_latency", 32'(k), 32'(ROM_LAT + 2));
    check_val("dbg_rd_data", 32'(dbg_rom_rdata), 32'(rom_f(24'h000010)));
    cycle();
    check_val("dbg_rvalid_pulse", 32'(dbg_rom_rvalid), 32'd0);
    check_val("dbg_rd_no_push", 32'(inst_valid), 32'd0);
    nx_inj = 1'b1; nx_dbg_inst = 8'hA5;
    cycle();
    nx_inj = 1'b0;
    cycle();
    check_val("inj_valid", 32'(inst_valid), 32'd1);
    check_val("inj_inst", 32'(inst), 32'h0000_00A5);
    check_val("inj_pc", 32'(inst_pc), 32'd0);
    nx_ready = 1'b1;
    cycle();
    nx_ready = 1'b0;
    cycle();
    check_val("inj_popped", 32'(inst_valid), 32'd0);
    // leave debug: fetch restarts from pc 0
    nx_dbg_en = 1'b0; nx_ready = 1'b1;
    chk_stream = 1'b1; exp_pc = '0; outstanding = 0;
    p0 = pops;
    cycle();
    repeat (20) cycle();
    check_val("dbg_exit_progress", 32'(pops - p0 > 0), 32'd1);

    // reset mid-run with a populated FIFO
    nx_ready = 1'b0;
    repeat (15) cycle();
    check_val("pre_rst_valid", 32'(inst_valid), 32'd1);
    nx_rst_n = 1'b0; chk_stream = 1'b0;
    cycle();
    cycle();
    check_val("mid_rst_valid", 32'(inst_valid), 32'd0);
    check_val("mid_rst_ren", 32'(rom_ren), 32'd0);
    check_val("mid_rst_raddr", 32'(rom_raddr), 32'd0);
    nx_rst_n = 1'b1; nx_timer = 1'b0;
    ren_cnt = 0;
    repeat (6) begin cycle(); ren_cnt += 32'(rom_ren); end
    check_val("post_rst_idle", 32'(ren_cnt), 32'd0);
    nx_timer = 1'b1; nx_ready = 1'b1;
    chk_stream = 1'b1; exp_pc = '0; outstanding = 0;
    repeat (12) cycle();

    // randomized traffic
    p0 = pops;
    for (int n = 0; n < 1500; n++) begin
      nx_ready  = ($urandom % 4) != 0;
      nx_pc_wen = ($urandom % 20) == 0;
      if ($urandom % 2 == 0) nx_pc_wdata = ADDR_W'($urandom);
      else nx_pc_wdata = 24'hFFFFF0 + ADDR_W'($urandom % 16);
      if ($urandom % 40 == 0) nx_timer = ~nx_timer;
      cycle();
    end
    check_val("random_progress", 32'(pops - p0 > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
Parametrised next-generation instruction fetch unit for the MCU. It streams sequential ROM reads into a small prefetch FIFO, so ROM latency is hidden from the decoder. Consumer handshake is valid/ready. Supports:
- configurable ROM read latency
- redirect flush on pc write
- debug ROM peek and instruction injection

Sits between the program ROM and the decode stage, gated by the timer run state.

Parameters:
ADDR_W, 24, ROM/pc address width
DATA_W, 8, instruction/ROM data width
ROM_LAT, 1, cycles from rom_ren asserted to rom_rdata valid (1..4)
FIFO_DEPTH, 4, prefetch FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
rom_ren  out  1  ROM read strobe (registered)
rom_raddr  out  ADDR_W  ROM read address (registered)
rom_rdata  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_ren
dbg_en  in  1  debug mode: halts fetch, resets pc
dbg_rom_ren  in  1  debug ROM read request
dbg_rom_raddr  in  ADDR_W  debug ROM read address
dbg_rom_rdata  out  DATA_W  debug read return data
dbg_rom_rvalid  out  1  one-cycle pulse with dbg_rom_rdata
dbg_inst_en  in  1  inject dbg_inst into FIFO
dbg_inst  in  DATA_W  injected instruction
timer_state  in  1  run enable
pc_wen  in  1  branch/redirect
pc_wdata  in  ADDR_W  redirect target
inst_valid  out  1  FIFO head valid
inst_ready  in  1  decoder accepts head
inst  out  DATA_W  FIFO head instruction
inst_pc  out  ADDR_W  address of head instruction (0 for injected)

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc=0; FIFO empty; in-flight tracker cleared; state ST_IDLE.
  - All outputs 0.
- State machine, in priority order:
  - dbg_en=1 -> ST_DBG from any state. Entry flushes FIFO and in-flight, pc<=0.
  - ST_DBG with dbg_en=0 -> ST_IDLE.
  - ST_IDLE with timer_state=1 -> ST_RUN.
  - ST_RUN with timer_state=0 -> ST_IDLE. Outstanding reads still complete into the FIFO.
- Fetch issue (ST_RUN only):
  - Condition: credit = FIFO_DEPTH - count - inflight > 0, and no dbg_rom_ren this cycle.
  - Action: next cycle rom_ren=1, rom_raddr=pc; pc<=pc+1.
  - pc wraps 2^ADDR_W-1 -> 0.
- In-flight tracking:
  - ROM_LAT-deep shift of {valid, is_dbg, addr}.
  - On exit, a fetch return pushes {rom_rdata, addr} to the FIFO. A debug return drives dbg_rom_rdata and pulses dbg_rom_rvalid.
- Debug read:
  - dbg_rom_ren has priority over fetch in any state.
  - Next cycle rom_ren=1, rom_raddr=dbg_rom_raddr.
  - Never pushes to the FIFO.
- Injection: dbg_inst_en pushes {dbg_inst, 0} in one cycle. It is dropped if the FIFO is full. The bench guarantees at most one in flight per instruction.
- FIFO:
  - Head is combinational from storage: inst_valid = count!=0.
  - Pop on inst_valid & inst_ready.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full cannot occur for fetches (credit rule).
- Redirect, pc_wen=1 (ignored in ST_DBG):
  - pc<=pc_wdata; FIFO cleared; in-flight fetch valids cleared. A return exiting this same cycle is discarded.
  - In-flight debug reads are preserved.
  - Pop in the redirect cycle is allowed; the head is then lost with the flush.
- Simultaneous dbg_en and pc_wen: dbg_en wins, pc<=0.
- Latency: pc redirect to first inst_valid = 1 (issue) + ROM_LAT + 1 (FIFO write) cycles.

Decomposition:
- Package fetch_pkg: state encodings ST_IDLE/ST_RUN/ST_DBG; function clog2 for pointer widths; in-flight entry field offsets.
- Sub-module fetch_fifo: parametrised DATA_W+ADDR_W wide, depth FIFO_DEPTH. Synchronous active-low clear plus flush input; outputs count, full, empty.

Test Plan:
1. ROM_LAT=1, rom model returns addr[7:0], timer_state=1, inst_ready=1 -> inst sequence 0x00,0x01,0x02 with inst_pc 0,1,2; first inst_valid 3 cycles after ST_RUN entry.
2. inst_ready=0 for 20 cycles -> count saturates at 4, no more rom_ren pulses; release -> 0..3 drained in order, no gaps or duplicates.
3. pc_wen with pc_wdata=0x000100 while 2 reads in flight -> stale data never appears; next inst_pc=0x000100.
4. ROM_LAT=3, pc preset 0xFFFFFE -> inst_pc 0xFFFFFE, 0xFFFFFF, 0x000000.
5. dbg_en=1, then dbg_rom_ren addr 0x10 -> dbg_rom_rvalid after ROM_LAT cycles, data 0x10, FIFO stays empty; dbg_inst_en with 0xA5 -> inst=0xA5, inst_pc=0.
6. rst_n=0 mid-run with FIFO holding 3 entries -> next cycle inst_valid=0, rom_ren=0, pc=0, state ST_IDLE.
